// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM with registered read data.
// Optional FIFO_CTRL_LEVEL_EN adds the level and almost_full outputs.
module fifo_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_ina,
    output logic              ram_enb,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_adb,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ovf
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] FULL_OCC   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ALMOST_OCC = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE_OCC    = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wptr, rptr;
    logic [ADDR_W:0]   occ;
    logic [ADDR_W:0]   stored;
    logic              full, push, pop, fetch;

    // A fetched-but-unpopped word is always the head, so it is exactly rd_valid.
    always_comb begin
        stored   = occ - {{ADDR_W{1'b0}}, rd_valid};
        full     = (occ == FULL_OCC) && !rst;
        wr_ready = !full;
        push     = wr_valid && wr_ready && !rst;
        pop      = rd_valid && rd_ready;
        fetch    = (stored != '0) && (!rd_valid || rd_ready) && !rst;
    end

    always_comb begin
        ram_ena = push;
        ram_wea = push;
        ram_ada = wptr;
        ram_ina = wr_data;
        ram_enb = fetch;
        ram_web = 1'b0;
        ram_adb = rptr;
        rd_data = ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            occ      <= '0;
            rd_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + ADDR_W'(1);
            if (fetch)
                rptr <= rptr + ADDR_W'(1);
            if (push && !pop)
                occ <= occ + ONE_OCC;
            else if (pop && !push)
                occ <= occ - ONE_OCC;
            if (fetch)
                rd_valid <= 1'b1;
            else if (pop)
                rd_valid <= 1'b0;
            if (wr_valid && full)
                ovf <= 1'b1;
        end
    end

`ifdef FIFO_CTRL_LEVEL_EN
    assign level       = occ;
    assign almost_full = (occ >= ALMOST_OCC);
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural dual-port RAM.
// Inputs change 1 time unit after each rising edge; outputs are checked 2 units later.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       rd_ready;
    logic       ram_ena, ram_wea, ram_enb, ram_web;
    logic [1:0] ram_ada, ram_adb;
    logic [3:0] ram_ina;
    logic [3:0] ram_rdata = 4'h0;
    logic       ovf;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [2:0] level;
    logic       almost_full;
`endif

    logic [3:0] mem [4];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_ctrl #(.DATA_W(4), .ADDR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_ada   (ram_ada),
        .ram_ina   (ram_ina),
        .ram_enb   (ram_enb),
        .ram_web   (ram_web),
        .ram_adb   (ram_adb),
        .ram_rdata (ram_rdata),
        .ovf       (ovf)
`ifdef FIFO_CTRL_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    always @(posedge clk) begin
        if (ram_ena && ram_wea)
            mem[ram_ada] <= ram_ina;
        if (ram_enb)
            ram_rdata <= mem[ram_adb];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, then let comb logic settle after input changes.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b1; wr_data = 4'hF; rd_ready = 1'b1;
        step();
        settle();
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_ena", 32'(ram_ena), 0);
        check("rst_enb", 32'(ram_enb), 0);
        step();

        // Single word latency
        rst = 1'b0; wr_valid = 1'b0;
        settle();
        check("post_rst_rd_valid", 32'(rd_valid), 0);
        check("post_rst_ovf", 32'(ovf), 0);
        check("post_rst_wr_ready", 32'(wr_ready), 1);
        check("web_zero", 32'(ram_web), 0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("post_rst_level", 32'(level), 0);
`endif
        step();
        wr_valid = 1'b1; wr_data = 4'h3; rd_ready = 1'b1;
        settle();
        check("c1_ena", 32'(ram_ena), 1);
        check("c1_wea", 32'(ram_wea), 1);
        check("c1_ada", 32'(ram_ada), 0);
        check("c1_ina", 32'(ram_ina), 3);
        check("c1_no_fetch", 32'(ram_enb), 0);
        step();
        wr_valid = 1'b0;
        settle();
        check("c2_enb", 32'(ram_enb), 1);
        check("c2_adb", 32'(ram_adb), 0);
        check("c2_rd_valid", 32'(rd_valid), 0);
        step();
        settle();
        check("c3_rd_valid", 32'(rd_valid), 1);
        check("c3_rd_data", 32'(rd_data), 3);
        step();
        settle();
        check("c4_rd_valid", 32'(rd_valid), 0);
        check("c4_enb", 32'(ram_enb), 0);
        step();

        // Fill to full, overflow, then drain
        rd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_data = 4'(i);
            settle();
            check("fill_wr_ready", 32'(wr_ready), 1);
`ifdef FIFO_CTRL_LEVEL_EN
            check("fill_almost_full", 32'(almost_full), (i == 4) ? 1 : 0);
`endif
            step();
        end
        wr_data = 4'h9;
        settle();
        check("full_wr_ready", 32'(wr_ready), 0);
        check("full_no_write", 32'(ram_ena), 0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("full_level", 32'(level), 4);
`endif
        step();
        wr_valid = 1'b0;
        settle();
        check("ovf_set", 32'(ovf), 1);
        check("full_head_valid", 32'(rd_valid), 1);
        check("full_head_data", 32'(rd_data), 1);
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            settle();
            check("drain_valid", 32'(rd_valid), 1);
            check("drain_data", 32'(rd_data), i);
            step();
        end
        settle();
        check("drain_empty", 32'(rd_valid), 0);
        check("ovf_sticky", 32'(ovf), 1);
        step();

        // Reset with three words held
        rd_ready = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            wr_valid = 1'b1; wr_data = 4'(i);
            step();
        end
        wr_valid = 1'b0;
        settle();
`ifdef FIFO_CTRL_LEVEL_EN
        check("pre_rst_level", 32'(level), 3);
`endif
        check("pre_rst_valid", 32'(rd_valid), 1);
        rst = 1'b1; rd_ready = 1'b1;
        settle();
        check("midrst_enb", 32'(ram_enb), 0);
        step();
        rst = 1'b0;
        settle();
        check("midrst_rd_valid", 32'(rd_valid), 0);
        check("midrst_wr_ready", 32'(wr_ready), 1);
        check("midrst_ovf", 32'(ovf), 0);
        check("midrst_enb_after", 32'(ram_enb), 0);
        wr_valid = 1'b1; wr_data = 4'hA;
        settle();
        check("midrst_ada", 32'(ram_ada), 0);
        step();
        wr_valid = 1'b0;
        settle();
        check("midrst_enb_fetch", 32'(ram_enb), 1);
        check("midrst_adb", 32'(ram_adb), 0);
        step();
        settle();
        check("midrst_valid", 32'(rd_valid), 1);
        check("midrst_data", 32'(rd_data), 32'hA);
        step();

        // Streaming 0..F, one per cycle, pointers start at 1
        rd_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_valid = (i < 16);
            wr_data  = 4'(i);
            settle();
            check("stream_wr_ready", 32'(wr_ready), 1);
            if (i < 16)
                check("stream_ada", 32'(ram_ada), (i + 1) % 4);
            if (i >= 1 && i <= 16) begin
                check("stream_enb", 32'(ram_enb), 1);
                check("stream_adb", 32'(ram_adb), i % 4);
            end
            check("stream_valid", 32'(rd_valid), (i >= 2) ? 1 : 0);
            if (i >= 2)
                check("stream_data", 32'(rd_data), i - 2);
            step();
        end
        wr_valid = 1'b0;
        settle();
        check("stream_end_valid", 32'(rd_valid), 0);
        step();

        // Stalled head while two more words arrive
        rd_ready = 1'b0; wr_valid = 1'b1; wr_data = 4'h5;
        step();
        wr_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            wr_valid = (k < 2);
            wr_data  = 4'(11 + k);
            settle();
            check("stall_valid", 32'(rd_valid), 1);
            check("stall_data", 32'(rd_data), 5);
            check("stall_no_enb", 32'(ram_enb), 0);
            step();
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        settle();
        check("resume_data", 32'(rd_data), 5);
        check("resume_enb", 32'(ram_enb), 1);
        step();
        settle();
        check("resume_b", 32'(rd_data), 32'hB);
        step();
        settle();
        check("resume_c", 32'(rd_data), 32'hC);
        check("resume_c_valid", 32'(rd_valid), 1);
        step();
        settle();
        check("resume_empty", 32'(rd_valid), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, width of one stored word; this width SHALL match the RAM read port.
REQ-002 Parameter ADDR_W, default 2, RAM address width; the FIFO depth SHALL be DEPTH = 2**ADDR_W.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port wr_valid, input, 1 bit: producer offers wr_data.
REQ-006 Port wr_data, input, DATA_W bits: word to enqueue.
REQ-007 Port wr_ready, output, 1 bit: FIFO can accept; SHALL equal !full.
REQ-008 Port rd_valid, output, 1 bit: rd_data holds the head word.
REQ-009 Port rd_data, output, DATA_W bits: head word; SHALL be driven directly from ram_rdata.
REQ-010 Port rd_ready, input, 1 bit: consumer takes the head word.
REQ-011 Port ram_ena, ram_wea, output, 1 bit each: RAM write-port enable and write strobe.
REQ-012 Port ram_ada, output, ADDR_W bits: RAM write address; ram_ina, output, DATA_W bits: RAM write data.
REQ-013 Port ram_enb, ram_web, output, 1 bit each: RAM read-port enable and write strobe; ram_web SHALL be constant 0.
REQ-014 Port ram_adb, output, ADDR_W bits: RAM read address; ram_rdata, input, DATA_W bits: RAM registered read data, valid one cycle after ram_enb.
REQ-015 Port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-016 push = wr_valid && wr_ready; when push=1, ram_ena=ram_wea=1, ram_ada=wptr and ram_ina=wr_data; otherwise ram_ena=ram_wea=0.
REQ-017 wptr SHALL increment modulo DEPTH on each push.
REQ-018 pop = rd_valid && rd_ready.
REQ-019 stored = count of words written but not yet fetched, taken from registered state only.
REQ-020 fetch = (stored > 0) && (!rd_valid || rd_ready); when fetch=1, ram_enb=1 and ram_adb=rptr, and rptr SHALL increment modulo DEPTH.
REQ-021 rd_valid SHALL be 1 in the cycle after a fetch. It SHALL clear in the cycle after a pop that has no fetch in the same cycle. It SHALL otherwise hold.
REQ-022 Read latency: a word pushed in cycle N SHALL appear with rd_valid=1 no earlier than cycle N+2.
REQ-023 Sustained throughput SHALL be one word per cycle on both sides.
REQ-024 Occupancy SHALL cover all words pushed and not yet popped, including the head word. Ranges: 0..DEPTH.
REQ-025 full = (occupancy == DEPTH).
REQ-026 A simultaneous push and pop when full SHALL be refused, because wr_ready=0.
REQ-027 A simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged.
REQ-028 A word pushed in cycle N SHALL NOT be fetched in cycle N; this rules out read-during-write hazards.
REQ-029 Order SHALL be strictly FIFO across pointer wrap-around.
REQ-030 wr_valid=1 while full SHALL set ovf=1 on the next edge; ovf SHALL hold until rst.
REQ-031 While rd_valid=1 and rd_ready=0, rd_data SHALL remain stable, since the RAM holds its output when ram_enb=0.

Reset
REQ-032 When rst=1 at an edge: wptr=0, rptr=0, occupancy=0, stored=0, rd_valid=0, ovf=0.
REQ-033 During and after reset, wr_ready=1 and all RAM enables=0.
REQ-034 Reset mid-operation SHALL discard all content; RAM contents SHALL be left as-is but become unreachable.
REQ-035 When rst=1, push and fetch SHALL be suppressed in that cycle.

Configuration
REQ-036 Macro FIFO_CTRL_LEVEL_EN defined: output level (ADDR_W+1 bits) SHALL equal occupancy, registered and updated on the same edge as the pointers.
REQ-037 Macro FIFO_CTRL_LEVEL_EN defined: output almost_full SHALL be 1 when occupancy >= DEPTH-1.
REQ-038 Macro FIFO_CTRL_LEVEL_EN undefined: ports level and almost_full SHALL be absent, with no other behavioural change.

Verification
REQ-039 Reset, then push 0x3 at cycle 1 with rd_ready=1 -> ram_enb=1 with adb=0 at cycle 2; rd_valid=1 and rd_data=0x3 at cycle 3; rd_valid=0 at cycle 4.
REQ-040 Push 0x1,0x2,0x3,0x4 with rd_ready=0 -> wr_ready=0 after the 4th push; extra wr_valid sets ovf=1; level=4 when the macro is enabled.
REQ-041 Continuous push of 0x0..0xF with rd_ready=1 -> rd_data reads 0x0..0xF in order, one per cycle after a 2-cycle start-up; wptr and rptr each wrap 4 times.
REQ-042 Head 0x5 valid and rd_ready held 0 for 5 cycles while 2 further pushes occur -> rd_data stays 0x5; no ram_enb pulse until rd_ready=1.
REQ-043 Occupancy 3, assert rst for one cycle -> next cycle rd_valid=0, wr_ready=1, ovf=0; a subsequent push of 0xA is read back via ram_adb=0.
